serial_bus_arbiter: RTL and testbench

- Two-master round-robin arbiter for the serial system bus.
- Decides which master's in/out datapath (MasterIn/MasterOut pair) owns the bus.
- Holds the grant for a whole single or burst transaction, counting completed bytes via done pulses from the active datapath.
- Forces release on an idle timeout.
- Drives the master-side mux select and busy indication to the bus/slave side.

---
 rtl/serial_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_serial_bus_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// Two-master round-robin arbiter for the serial system bus.
// Owns the bus for a whole single/burst transaction, counting completed
// bytes from the active datapath, with an idle-timeout forced release.
module serial_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 200,
  parameter int unsigned BURST_W        = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m1_req,
  input  logic               m2_req,
  input  logic [BURST_W-1:0] m1_burst_num,
  input  logic [BURST_W-1:0] m2_burst_num,
  input  logic               byte_done,
  output logic               m1_grant,
  output logic               m2_grant,
  output logic               master_sel,
  output logic               bus_busy,
  output logic [BURST_W-1:0] bytes_left,
  output logic               timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  // Master encoding shared by master_sel and last_served.
  localparam logic SEL_M1 = 1'b0;
  localparam logic SEL_M2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state;
  logic             last_served;
  logic [CNT_W-1:0] idle_cnt;

  logic pick_m2_c;
  logic granted_req_c;
  logic last_byte_c;
  logic terminal_c;

  // Arbitration and in-transaction status decode.
  always_comb begin
    pick_m2_c     = 1'b0;
    granted_req_c = 1'b0;
    last_byte_c   = 1'b0;
    terminal_c    = 1'b0;
    // Master 2 wins if alone, or on a tie when master 1 was served last.
    pick_m2_c     = m2_req && (!m1_req || (last_served == SEL_M1));
    granted_req_c = (master_sel == SEL_M2) ? m2_req : m1_req;
    last_byte_c   = byte_done && (bytes_left == '0);
    terminal_c    = (idle_cnt == CNT_TERM);
  end

  // Arbiter state machine with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_served <= SEL_M2;
      idle_cnt    <= '0;
      m1_grant    <= 1'b0;
      m2_grant    <= 1'b0;
      master_sel  <= SEL_M1;
      bus_busy    <= 1'b0;
      bytes_left  <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (m1_req || m2_req) begin
            state      <= GRANT;
            master_sel <= pick_m2_c ? SEL_M2 : SEL_M1;
            bytes_left <= pick_m2_c ? m2_burst_num : m1_burst_num;
            idle_cnt   <= '0;
          end
        end

        GRANT: begin
          state    <= ACTIVE;
          m1_grant <= (master_sel == SEL_M1);
          m2_grant <= (master_sel == SEL_M2);
          bus_busy <= 1'b1;
        end

        ACTIVE: begin
          // A completed byte always consumes one count, even on an abort.
          if (byte_done && (bytes_left != '0)) begin
            bytes_left <= bytes_left - BURST_W'(1);
          end
          if (!granted_req_c || last_byte_c) begin
            // Abort or normal completion; never a timeout pulse.
            state    <= RELEASE;
            m1_grant <= 1'b0;
            m2_grant <= 1'b0;
            bus_busy <= 1'b0;
          end else if (byte_done) begin
            // Progress on the terminal cycle beats the timeout.
            idle_cnt <= '0;
          end else if (terminal_c) begin
            state    <= RELEASE;
            m1_grant <= 1'b0;
            m2_grant <= 1'b0;
            bus_busy <= 1'b0;
            timeout  <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end

        RELEASE: begin
          last_served <= master_sel;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed self-checking bench for serial_bus_arbiter.
module tb_serial_bus_arbiter;

  localparam int unsigned BURST_W = 12;
  localparam int unsigned TO      = 20;

  logic               clk;
  logic               reset;
  logic               m1_req;
  logic               m2_req;
  logic [BURST_W-1:0] m1_burst_num;
  logic [BURST_W-1:0] m2_burst_num;
  logic               byte_done;
  logic               m1_grant;
  logic               m2_grant;
  logic               master_sel;
  logic               bus_busy;
  logic [BURST_W-1:0] bytes_left;
  logic               timeout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_bus_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .BURST_W       (BURST_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m1_req      (m1_req),
    .m2_req      (m2_req),
    .m1_burst_num(m1_burst_num),
    .m2_burst_num(m2_burst_num),
    .byte_done   (byte_done),
    .m1_grant    (m1_grant),
    .m2_grant    (m2_grant),
    .master_sel  (master_sel),
    .bus_busy    (bus_busy),
    .bytes_left  (bytes_left),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m1_req = 1'b0; m2_req = 1'b0;
    m1_burst_num = '0; m2_burst_num = '0;
    byte_done = 1'b0;
    tick(); tick();
    n_checks++;
    if ({m1_grant, m2_grant, master_sel, bus_busy, timeout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {m1_grant, m2_grant, master_sel, bus_busy, timeout});
    end
    n_checks++;
    if (bytes_left !== 12'd0) begin
      n_fail++; $display("FAIL reset_bytes_left: got %0d expected 0", bytes_left);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({m1_grant, m2_grant, bus_busy} !== 3'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {m1_grant, m2_grant, bus_busy});
    end
  endtask

  task automatic test_single_read();
    m1_burst_num = 12'd0;
    m1_req = 1'b1;
    tick();
    n_checks++;
    if (m1_grant !== 1'b0) begin
      n_fail++; $display("FAIL single_grant_early: got %b expected 0", m1_grant);
    end
    tick();
    n_checks++;
    if ({m1_grant, m2_grant, bus_busy, master_sel} !== 4'b1010) begin
      n_fail++; $display("FAIL single_grant: got %b expected 1010", {m1_grant, m2_grant, bus_busy, master_sel});
    end
    n_checks++;
    if (bytes_left !== 12'd0) begin
      n_fail++; $display("FAIL single_bytes_left: got %0d expected 0", bytes_left);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if ({m1_grant, timeout} !== 2'b10) begin
        n_fail++; $display("FAIL single_hold_%0d: got %b expected 10", i, {m1_grant, timeout});
      end
    end
    byte_done = 1'b1;
    tick();
    byte_done = 1'b0;
    m1_req = 1'b0;
    n_checks++;
    if ({m1_grant, bus_busy, timeout} !== 3'b000) begin
      n_fail++; $display("FAIL single_release: got %b expected 000", {m1_grant, bus_busy, timeout});
    end
    tick(); tick();
  endtask

  task automatic test_burst();
    m2_burst_num = 12'd3;
    m2_req = 1'b1;
    tick();
    n_checks++;
    if ({master_sel, bytes_left} !== {1'b1, 12'd3}) begin
      n_fail++; $display("FAIL burst_load: got sel=%b left=%0d expected sel=1 left=3", master_sel, bytes_left);
    end
    tick();
    n_checks++;
    if ({m1_grant, m2_grant, bus_busy} !== 3'b011) begin
      n_fail++; $display("FAIL burst_grant: got %b expected 011", {m1_grant, m2_grant, bus_busy});
    end
    for (int k = 0; k < 4; k++) begin
      repeat (9) tick();
      byte_done = 1'b1;
      tick();
      byte_done = 1'b0;
      n_checks++;
      if (bytes_left !== BURST_W'(k < 3 ? 2 - k : 0)) begin
        n_fail++; $display("FAIL burst_left_%0d: got %0d expected %0d", k, bytes_left, (k < 3 ? 2 - k : 0));
      end
      n_checks++;
      if (m2_grant !== (k < 3)) begin
        n_fail++; $display("FAIL burst_grant_%0d: got %b expected %b", k, m2_grant, (k < 3));
      end
    end
    m2_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_contention();
    int order[4];
    int gap;
    int waited;
    int who;
    order[0] = 1; order[1] = 2; order[2] = 1; order[3] = 2;
    reset = 1'b0;
    m1_burst_num = '0; m2_burst_num = '0;
    m1_req = 1'b1; m2_req = 1'b1;
    tick();
    reset = 1'b1;
    gap = 0;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (!m1_grant && !m2_grant && waited < 20) begin
        tick();
        waited++;
        if (!m1_grant && !m2_grant) gap++;
      end
      n_checks++;
      if (waited >= 20) begin
        n_fail++; $display("FAIL rr_wait_%0d: got no grant expected grant within 20 cycles", k);
      end
      n_checks++;
      if (m1_grant && m2_grant) begin
        n_fail++; $display("FAIL rr_both_%0d: got both grants expected one", k);
      end
      who = m1_grant ? 1 : (m2_grant ? 2 : 0);
      n_checks++;
      if (who !== order[k]) begin
        n_fail++; $display("FAIL rr_order_%0d: got master %0d expected master %0d", k, who, order[k]);
      end
      if (k > 0) begin
        n_checks++;
        if (gap < 2) begin
          n_fail++; $display("FAIL rr_gap_%0d: got %0d dead cycles expected >=2", k, gap);
        end
      end
      byte_done = 1'b1;
      tick();
      byte_done = 1'b0;
      gap = 1;
    end
    m1_req = 1'b0; m2_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    m1_burst_num = 12'd2;
    m1_req = 1'b1;
    tick(); tick();
    byte_done = 1'b1;
    tick();
    byte_done = 1'b0;
    n_checks++;
    if (bytes_left !== 12'd1) begin
      n_fail++; $display("FAIL to_left: got %0d expected 1", bytes_left);
    end
    m2_req = 1'b1;
    for (int i = 1; i < 20; i++) begin
      tick();
      n_checks++;
      if ({m1_grant, m2_grant, timeout} !== 3'b100) begin
        n_fail++; $display("FAIL to_wait_%0d: got %b expected 100", i, {m1_grant, m2_grant, timeout});
      end
    end
    tick();
    n_checks++;
    if ({m1_grant, bus_busy, timeout} !== 3'b001) begin
      n_fail++; $display("FAIL to_pulse: got %b expected 001", {m1_grant, bus_busy, timeout});
    end
    tick();
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL to_one_cycle: got %b expected 0", timeout);
    end
    tick(); tick();
    n_checks++;
    if ({m1_grant, m2_grant} !== 2'b01) begin
      n_fail++; $display("FAIL to_next_m2: got %b expected 01", {m1_grant, m2_grant});
    end
    m1_req = 1'b0; m2_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_abort();
    m1_burst_num = 12'd5;
    m1_req = 1'b1;
    tick(); tick();
    byte_done = 1'b1;
    tick();
    byte_done = 1'b0;
    tick(); tick();
    byte_done = 1'b1;
    m1_req = 1'b0;
    tick();
    byte_done = 1'b0;
    n_checks++;
    if ({m1_grant, bus_busy, timeout} !== 3'b000) begin
      n_fail++; $display("FAIL abort_release: got %b expected 000", {m1_grant, bus_busy, timeout});
    end
    n_checks++;
    if (bytes_left !== 12'd3) begin
      n_fail++; $display("FAIL abort_left: got %0d expected 3", bytes_left);
    end
    tick();
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_timeout: got %b expected 0", timeout);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    m1_burst_num = 12'd7;
    m1_req = 1'b1;
    tick(); tick();
    byte_done = 1'b1;
    tick();
    byte_done = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({m1_grant, m2_grant, bus_busy} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_flags: got %b expected 000", {m1_grant, m2_grant, bus_busy});
    end
    n_checks++;
    if (bytes_left !== 12'd0) begin
      n_fail++; $display("FAIL rst_mid_left: got %0d expected 0", bytes_left);
    end
    m2_req = 1'b1;
    tick();
    reset = 1'b1;
    tick(); tick();
    n_checks++;
    if ({m1_grant, m2_grant} !== 2'b10) begin
      n_fail++; $display("FAIL rst_first_m1: got %b expected 10", {m1_grant, m2_grant});
    end
    m1_req = 1'b0; m2_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_collisions();
    m1_burst_num = 12'd3;
    m1_req = 1'b1;
    tick(); tick();
    repeat (19) tick();
    byte_done = 1'b1;
    tick();
    byte_done = 1'b0;
    n_checks++;
    if ({m1_grant, timeout, bytes_left} !== {2'b10, 12'd2}) begin
      n_fail++; $display("FAIL coll_term: got grant=%b to=%b left=%0d expected grant=1 to=0 left=2",
                         m1_grant, timeout, bytes_left);
    end
    repeat (19) tick();
    n_checks++;
    if ({m1_grant, timeout} !== 2'b10) begin
      n_fail++; $display("FAIL coll_cnt_cleared: got %b expected 10", {m1_grant, timeout});
    end
    tick();
    n_checks++;
    if (timeout !== 1'b1) begin
      n_fail++; $display("FAIL coll_late_timeout: got %b expected 1", timeout);
    end
    m1_req = 1'b0;
    tick(); tick();
    // byte_done held through IDLE and GRANT must not consume a count.
    m2_burst_num = 12'd2;
    m2_req = 1'b1;
    byte_done = 1'b1;
    tick();
    n_checks++;
    if (bytes_left !== 12'd2) begin
      n_fail++; $display("FAIL coll_idle_done: got %0d expected 2", bytes_left);
    end
    tick();
    byte_done = 1'b0;
    n_checks++;
    if ({m2_grant, bytes_left} !== {1'b1, 12'd2}) begin
      n_fail++; $display("FAIL coll_grant_done: got grant=%b left=%0d expected grant=1 left=2", m2_grant, bytes_left);
    end
    m2_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_max_burst();
    m1_burst_num = 12'd4095;
    m1_req = 1'b1;
    tick();
    n_checks++;
    if (bytes_left !== 12'd4095) begin
      n_fail++; $display("FAIL max_load: got %0d expected 4095", bytes_left);
    end
    tick();
    byte_done = 1'b1;
    tick();
    byte_done = 1'b0;
    n_checks++;
    if ({m1_grant, bytes_left} !== {1'b1, 12'd4094}) begin
      n_fail++; $display("FAIL max_dec: got grant=%b left=%0d expected grant=1 left=4094", m1_grant, bytes_left);
    end
    m1_req = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst();
    test_contention();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_collisions();
    test_max_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
